scope_capture_ctrl: RTL and testbench
=====================================

// Module: scope_capture_ctrl
// PURPOSE
//  Sequences waveform acquisition for the oscilloscope. Streams ADC samples into a
//  2^ADDR_W-entry circular sample RAM, detects the trigger edge, and stops after
//  the post-trigger count. It commits the display start address only at a VGA
//  frame boundary, so the pixel renderer never shows a half-written trace.
//  Sits between the ADC sampler, the sample RAM write port and the VGA timing block.
// PARAMETERS
//  ADDR_W      9    sample RAM address width; DEPTH = 2^ADDR_W = 512
//  DATA_W      8    sample width, unsigned
//  PRETRIG     64   samples kept before the trigger point; 1 <= PRETRIG < DEPTH-1
//  AUTO_FRAMES 8    frame_start pulses without a trigger before auto-trigger (AUTO mode)
// PORTS
//  clk         in   1       system clock
//  clr         in   1       asynchronous reset, active-low (clr=0 resets)
//  smp_valid   in   1       one-cycle strobe: smp_data holds a new ADC sample
//  smp_data    in   DATA_W  ADC sample
//  trig_level  in   DATA_W  trigger threshold, unsigned
//  trig_fall   in   1       0 = rising-edge trigger, 1 = falling-edge trigger
//  auto_en     in   1       1 = AUTO mode (timeout forces a capture)
//  run         in   1       1 = re-arm continuously after each capture
//  single      in   1       one-cycle pulse: start one capture from IDLE
//  frame_start in   1       one-cycle pulse from VGA timing at hc==0, vc==0
//  wr_en       out  1       sample RAM write enable
//  wr_addr     out  ADDR_W  sample RAM write address
//  wr_data     out  DATA_W  sample RAM write data
//  disp_base   out  ADDR_W  RAM address shown at the left edge of the trace
//  buf_ready   out  1       one-cycle pulse when disp_base is updated
//  triggered   out  1       1 = last committed capture was a real trigger (0 = auto)
//  state       out  3       FSM state: 0 IDLE, 1 PREFILL, 2 ARMED, 3 POST, 4 HOLD
// BEHAVIOUR
//  Reset: state=IDLE, wptr=0, wr_en=0, wr_addr=0, wr_data=0, disp_base=0,
//   buf_ready=0, triggered=0, prev=0, all counters 0.
//  Write path (PREFILL/ARMED/POST only): a sample strobe at cycle N gives
//   wr_en=1 at N+1 with wr_addr=wptr(N) and wr_data=smp_data(N). All outputs are registered.
//  wptr increments by 1 per accepted sample, mod DEPTH; it wraps 511->0.
//  prev <= smp_data on every accepted sample.
//  No writes occur in IDLE or HOLD; smp_valid is ignored there.
//  IDLE: run=1 or single=1 -> PREFILL, with pre_cnt=0.
//  PREFILL: count accepted samples; on the PRETRIG-th sample -> ARMED.
//  ARMED: on each sample, check the edge against trig_level.
//   Rising edge: prev < trig_level && smp_data >= trig_level.
//   Falling edge: prev > trig_level && smp_data <= trig_level.
//   On an edge: trig_addr <= wptr (address of this sample), trig_flag <= 1, -> POST.
//   Auto-trigger: if auto_en=1, count frame_start pulses while ARMED. Once the count
//    reaches AUTO_FRAMES, the next sample forces the trigger with trig_flag <= 0.
//   trig_level and trig_fall are sampled live, so a change takes effect on the next sample.
//  POST: count DEPTH-PRETRIG-1 further samples. On the last one -> HOLD.
//   The RAM then holds exactly DEPTH samples, the oldest at trig_addr-PRETRIG.
//  HOLD: wait for frame_start. Then, in the same edge:
//   disp_base <= (trig_addr - PRETRIG) mod DEPTH; triggered <= trig_flag; buf_ready=1.
//   Next state is PREFILL if run=1, else IDLE.
//  frame_start in the same cycle as the HOLD entry does not count; commit waits for
//   the next frame_start.
//  A sample strobe and frame_start in the same cycle are both honoured.
//  Clearing run mid-capture lets the capture finish through HOLD, then IDLE.
//  single is ignored outside IDLE.
//  Reset mid-operation returns immediately to the reset values above.
//  A partially written buffer is never committed: disp_base keeps its last value.
// TESTING
//  Ramp 0..255 repeating, level=100, rising, run=1, PRETRIG=64 -> trigger at the sample
//   value 100; disp_base = trig_addr-64 mod 512; buf_ready on the first frame_start after HOLD.
//  Same ramp, trig_fall=1, level=100 -> no trigger. Then smp_data 200 followed by 50 ->
//   trigger on the 50 sample.
//  Constant input 10, level=100, auto_en=1 -> after 8 frame_starts in ARMED, forced capture;
//   triggered=0.
//  Same constant input with auto_en=0 -> stays in ARMED indefinitely; wr_en keeps toggling.
//  Trigger when wptr=20 -> disp_base=468 (wrap case); single with run=0 -> one capture, then IDLE.
//  clr pulled low during POST -> all outputs reset; wr_en=0 on the next cycle after
//   clr is released with no strobe.

Source files
------------

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope acquisition sequencer: streams ADC samples into a circular RAM,
// detects the trigger edge and commits the display base only at a VGA frame boundary.
module scope_capture_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 8,
    parameter int PRETRIG     = 64,
    parameter int AUTO_FRAMES = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_fall,
    input  logic              auto_en,
    input  logic              run,
    input  logic              single,
    input  logic              frame_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] disp_base,
    output logic              buf_ready,
    output logic              triggered,
    output logic [2:0]        state
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int AUTO_W = $clog2(AUTO_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t              cur, nxt;
    logic [ADDR_W-1:0]   wptr, pre_cnt, post_cnt, trig_addr;
    logic [AUTO_W-1:0]   auto_cnt;
    logic [DATA_W-1:0]   prev;
    logic                trig_flag;
    logic                accept, edge_hit, force_hit, trig_now, commit;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) cur <= IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        trig_now = 1'b0;
        commit   = 1'b0;
        accept   = smp_valid && (cur == PREFILL || cur == ARMED || cur == POST);
        edge_hit = trig_fall ? (prev > trig_level && smp_data <= trig_level)
                             : (prev < trig_level && smp_data >= trig_level);
        force_hit = auto_en && (auto_cnt >= AUTO_W'(AUTO_FRAMES));
        case (cur)
            IDLE:    if (run || single) nxt = PREFILL;
            PREFILL: if (accept && pre_cnt == ADDR_W'(PRETRIG - 1)) nxt = ARMED;
            ARMED: begin
                if (accept && (edge_hit || force_hit)) begin
                    trig_now = 1'b1;
                    nxt      = POST;
                end
            end
            POST:    if (accept && post_cnt == ADDR_W'(DEPTH - PRETRIG - 2)) nxt = HOLD;
            HOLD: begin
                if (frame_start) begin
                    commit = 1'b1;
                    nxt    = run ? PREFILL : IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Counters clear whenever their owning state is not active, so every re-arm starts fresh.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wptr      <= '0;
            prev      <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            auto_cnt  <= '0;
            trig_addr <= '0;
            trig_flag <= 1'b0;
            disp_base <= '0;
            triggered <= 1'b0;
            buf_ready <= 1'b0;
        end else begin
            wr_en     <= accept;
            buf_ready <= commit;
            if (accept) begin
                wr_addr <= wptr;
                wr_data <= smp_data;
                wptr    <= wptr + 1'b1;
                prev    <= smp_data;
            end
            if (cur != PREFILL)  pre_cnt <= '0;
            else if (accept)     pre_cnt <= pre_cnt + 1'b1;
            if (cur != POST)     post_cnt <= '0;
            else if (accept)     post_cnt <= post_cnt + 1'b1;
            if (cur != ARMED)
                auto_cnt <= '0;
            else if (auto_en && frame_start && auto_cnt < AUTO_W'(AUTO_FRAMES))
                auto_cnt <= auto_cnt + 1'b1;
            if (trig_now) begin
                trig_addr <= wptr;
                trig_flag <= edge_hit;
            end
            if (commit) begin
                disp_base <= trig_addr - ADDR_W'(PRETRIG);
                triggered <= trig_flag;
            end
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Directed self-checking bench for scope_capture_ctrl with hand-computed addresses.
module tb_scope_capture_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       smp_valid = 1'b0;
    logic [7:0] smp_data = '0;
    logic [7:0] trig_level = '0;
    logic       trig_fall = 1'b0;
    logic       auto_en = 1'b0;
    logic       run = 1'b0;
    logic       single = 1'b0;
    logic       frame_start = 1'b0;
    logic       wr_en;
    logic [8:0] wr_addr;
    logic [7:0] wr_data;
    logic [8:0] disp_base;
    logic       buf_ready;
    logic       triggered;
    logic [2:0] state;

    int compared = 0;
    int mismatched = 0;

    scope_capture_ctrl dut (
        .clk(clk), .clr(clr), .smp_valid(smp_valid), .smp_data(smp_data),
        .trig_level(trig_level), .trig_fall(trig_fall), .auto_en(auto_en),
        .run(run), .single(single), .frame_start(frame_start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .disp_base(disp_base), .buf_ready(buf_ready), .triggered(triggered),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock: inputs held across the edge, outputs readable on return, pulses dropped.
    task automatic applyStimulus(input logic v, input int d, input logic fs);
        smp_valid   = v;
        smp_data    = 8'(d);
        frame_start = fs;
        @(posedge clk);
        #1;
        smp_valid   = 1'b0;
        frame_start = 1'b0;
        single      = 1'b0;
    endtask

    task automatic streamRamp(input int first, input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, (first + i) % 256, 1'b0);
    endtask

    task automatic streamConst(input int count, input int val);
        for (int i = 0; i < count; i++) applyStimulus(1'b1, val, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        checkOutput("rst_disp_base", disp_base, 0);
        checkOutput("rst_buf_ready", buf_ready, 0);
        checkOutput("rst_triggered", triggered, 0);
        clr = 1'b1;

        // Rising ramp trigger at value 100, address 100
        $display("[TB] rising ramp capture");
        run = 1'b1;
        trig_level = 8'd100;
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("idle_to_prefill", state, 1);
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("first_wr_en", wr_en, 1);
        checkOutput("first_wr_addr", wr_addr, 0);
        checkOutput("first_wr_data", wr_data, 0);
        streamRamp(1, 62);
        checkOutput("prefill_63", state, 1);
        streamRamp(63, 1);
        checkOutput("prefill_done", state, 2);
        streamRamp(64, 36);
        checkOutput("armed_below", state, 2);
        applyStimulus(1'b1, 100, 1'b0);
        checkOutput("rise_trig_state", state, 3);
        checkOutput("rise_trig_addr", wr_addr, 100);
        streamRamp(101, 446);
        checkOutput("post_not_done", state, 3);
        applyStimulus(1'b1, 35, 1'b1);
        checkOutput("hold_entry", state, 4);
        checkOutput("hold_entry_fs_ignored", buf_ready, 0);
        applyStimulus(1'b1, 7, 1'b0);
        checkOutput("hold_no_write", wr_en, 0);
        checkOutput("hold_stays", state, 4);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("commit1_ready", buf_ready, 1);
        checkOutput("commit1_base", disp_base, 36);
        checkOutput("commit1_trig", triggered, 1);
        checkOutput("commit1_rearm", state, 1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("ready_pulse_end", buf_ready, 0);

        // Falling edge: ramp alone never crosses downward, 200 then 50 does
        $display("[TB] falling edge capture");
        trig_fall = 1'b1;
        streamRamp(0, 64);
        checkOutput("fall_armed", state, 2);
        streamRamp(64, 192);
        checkOutput("fall_ramp_no_trig", state, 2);
        applyStimulus(1'b1, 200, 1'b0);
        checkOutput("fall_200_no_trig", state, 2);
        applyStimulus(1'b1, 50, 1'b0);
        checkOutput("fall_trig_state", state, 3);
        checkOutput("fall_trig_addr", wr_addr, 293);
        checkOutput("fall_trig_data", wr_data, 50);
        run = 1'b0;
        streamConst(446, 0);
        applyStimulus(1'b1, 0, 1'b0);
        checkOutput("fall_hold", state, 4);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("fall_base", disp_base, 229);
        checkOutput("fall_trig", triggered, 1);
        checkOutput("run_cleared_idle", state, 0);

        // Auto trigger after 8 frames in ARMED
        $display("[TB] auto trigger");
        trig_fall = 1'b0;
        auto_en = 1'b1;
        single = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("single_start", state, 1);
        streamConst(64, 10);
        checkOutput("auto_armed", state, 2);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b1, 10, 1'b0);
        checkOutput("auto_7_frames", state, 2);
        checkOutput("auto_7_addr", wr_addr, 293);
        applyStimulus(1'b0, 0, 1'b1);
        applyStimulus(1'b1, 10, 1'b0);
        checkOutput("auto_forced", state, 3);
        checkOutput("auto_forced_addr", wr_addr, 294);
        streamConst(447, 10);
        checkOutput("auto_hold", state, 4);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("auto_base", disp_base, 230);
        checkOutput("auto_triggered", triggered, 0);
        checkOutput("auto_idle", state, 0);

        // No auto: stays ARMED, then a rising edge at address 20 wraps disp_base
        $display("[TB] no auto and wrap");
        auto_en = 1'b0;
        single = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        streamConst(64, 10);
        for (int i = 0; i < 12; i++) applyStimulus(1'b1, 10, 1'b1);
        checkOutput("noauto_armed", state, 2);
        checkOutput("noauto_wr_en", wr_en, 1);
        checkOutput("noauto_addr", wr_addr, 305);
        streamConst(206, 10);
        checkOutput("addr_511", wr_addr, 511);
        streamConst(20, 10);
        checkOutput("addr_wrapped", wr_addr, 19);
        checkOutput("still_armed", state, 2);
        applyStimulus(1'b1, 150, 1'b0);
        checkOutput("wrap_trig_state", state, 3);
        checkOutput("wrap_trig_addr", wr_addr, 20);
        single = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("single_ignored", state, 3);
        streamConst(447, 10);
        checkOutput("wrap_hold", state, 4);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("wrap_base", disp_base, 468);
        checkOutput("wrap_triggered", triggered, 1);
        checkOutput("wrap_idle", state, 0);

        // Asynchronous reset during POST
        $display("[TB] reset during post");
        run = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        streamConst(64, 0);
        applyStimulus(1'b1, 150, 1'b0);
        streamConst(10, 0);
        checkOutput("pre_reset_post", state, 3);
        #3;
        clr = 1'b0;
        #1;
        checkOutput("areset_state", state, 0);
        checkOutput("areset_wr_en", wr_en, 0);
        checkOutput("areset_wr_addr", wr_addr, 0);
        checkOutput("areset_disp_base", disp_base, 0);
        checkOutput("areset_triggered", triggered, 0);
        run = 1'b0;
        @(posedge clk);
        #1;
        clr = 1'b1;
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("post_release_wr_en", wr_en, 0);
        checkOutput("post_release_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
